// File: rtl/mac_seq_ctrl_if.sv
// Operand, mac and result signals of one mac_seq_ctrl sequencer.
// slave is the controller's view; master is the host/mac side.
interface mac_seq_ctrl_if #(
   parameter int D_W     = 4,
   parameter int D_W_ACC = 8,
   parameter int LEN_W   = 8
);
   logic               start;
   logic [LEN_W-1:0]   len;
   logic               in_valid;
   logic               in_ready;
   logic [D_W-1:0]     in_a;
   logic [D_W-1:0]     in_b;
   logic [D_W-1:0]     mac_a;
   logic [D_W-1:0]     mac_b;
   logic               mac_init;
   logic [D_W_ACC-1:0] mac_result;
   logic               out_valid;
   logic               out_ready;
   logic [D_W_ACC-1:0] out_data;
   logic               busy;

   modport slave (
      input  start, len, in_valid, in_a, in_b, mac_result, out_ready,
      output in_ready, mac_a, mac_b, mac_init, out_valid, out_data, busy
   );

   modport master (
      output start, len, in_valid, in_a, in_b, mac_result, out_ready,
      input  in_ready, mac_a, mac_b, mac_init, out_valid, out_data, busy
   );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one accumulating mac: one dot product per start command.
// Operand pairs stream through to the mac combinationally; the first beat
// carries the initialize strobe, the final sum is captured one cycle after
// the last beat and offered on a valid/ready result port.
module mac_seq_ctrl #(
   parameter int D_W     = 4,
   parameter int D_W_ACC = 8,
   parameter int LEN_W   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   mac_seq_ctrl_if.slave       bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [D_W_ACC-1:0] out_data_q, out_data_d;
   logic               beat;

   // Operand path: only an accepted RUN beat reaches the mac; bubbles feed
   // zeros so the accumulator holds its value.
   always_comb begin
      beat         = (state_q == RUN) && bus.in_valid;
      bus.in_ready = (state_q == RUN);
      bus.mac_a    = beat ? bus.in_a : {D_W{1'b0}};
      bus.mac_b    = beat ? bus.in_b : {D_W{1'b0}};
      bus.mac_init = beat && (beat_cnt_q == '0);
      bus.out_valid = (state_q == DONE);
      bus.out_data  = out_data_q;
      bus.busy      = (state_q != IDLE);
   end

   // Next-state logic; beat_cnt stops at len_q so len = 2^LEN_W-1 never wraps.
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      len_d      = len_q;
      out_data_d = out_data_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               len_d      = bus.len;
               beat_cnt_d = '0;
               if (bus.len != '0) begin
                  state_d = RUN;
               end else begin
                  out_data_d = '0;
                  state_d    = DONE;
               end
            end
         end
         RUN: begin
            if (beat) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == len_q - 1'b1) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // The mac registered the final sum at the last beat's edge.
            out_data_d = bus.mac_result;
            state_d    = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any command in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         len_q      <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         len_q      <= len_d;
         out_data_q <= out_data_d;
      end
   end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural mac model, directed commands, and a
// scoreboard of hand-computed dot products checked by an output monitor.
module tb_mac_seq_ctrl;

   localparam int D_W     = 4;
   localparam int D_W_ACC = 8;
   localparam int LEN_W   = 8;

   logic clk = 1'b0;
   logic rst_n;

   mac_seq_ctrl_if #(.D_W(D_W), .D_W_ACC(D_W_ACC), .LEN_W(LEN_W)) bus ();

   mac_seq_ctrl #(.D_W(D_W), .D_W_ACC(D_W_ACC), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Accumulating mac: initialize overwrites, otherwise adds; wraps mod 2^8.
   logic [D_W_ACC-1:0] acc = '0;
   always @(posedge clk) begin
      if (bus.mac_init)
         acc <= D_W_ACC'(bus.mac_a * bus.mac_b);
      else
         acc <= acc + D_W_ACC'(bus.mac_a * bus.mac_b);
   end
   assign bus.mac_result = acc;

   int n_cmp = 0;
   int n_err = 0;
   logic [D_W_ACC-1:0] exp_q[$];
   logic [D_W-1:0] va[0:255];
   logic [D_W-1:0] vb[0:255];

   task automatic chk(input string name, input int act, input int expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // Monitor: every result handshake is checked against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result: got %0d, expected no result", bus.out_data);
         end else begin
            chk("result", int'(bus.out_data), int'(exp_q.pop_front()));
         end
      end
   end

   // Issue one command. Leaves the bench in the first DONE cycle (hold=1)
   // or just after the handshake cycle (hold=0).
   task automatic do_cmd(input int n, input int gap, input int expv, input bit hold);
      @(posedge clk); #1;
      exp_q.push_back(D_W_ACC'(expv));
      bus.start = 1'b1;
      bus.len   = LEN_W'(n);
      @(negedge clk);
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_in_ready", int'(bus.in_ready), 0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (n == 0) begin
         @(negedge clk);
         chk("zero_in_ready", int'(bus.in_ready), 0);
         chk("zero_mac_init", int'(bus.mac_init), 0);
         chk("zero_out_valid", int'(bus.out_valid), 1);
      end else begin
         for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
               bus.in_valid = 1'b0;
               bus.in_a     = 4'd9;
               bus.in_b     = 4'd9;
               @(negedge clk);
               chk("gap_in_ready", int'(bus.in_ready), 1);
               chk("gap_mac_a", int'(bus.mac_a), 0);
               chk("gap_mac_b", int'(bus.mac_b), 0);
               chk("gap_mac_init", int'(bus.mac_init), 0);
               @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_a     = va[i];
            bus.in_b     = vb[i];
            @(negedge clk);
            chk("beat_in_ready", int'(bus.in_ready), 1);
            chk("beat_mac_a", int'(bus.mac_a), int'(va[i]));
            chk("beat_mac_b", int'(bus.mac_b), int'(vb[i]));
            chk("beat_mac_init", int'(bus.mac_init), (i == 0) ? 1 : 0);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         chk("drain_out_valid", int'(bus.out_valid), 0);
         chk("drain_in_ready", int'(bus.in_ready), 0);
         chk("drain_mac_init", int'(bus.mac_init), 0);
         @(posedge clk); #1;
         @(negedge clk);
         chk("done_out_valid", int'(bus.out_valid), 1);
      end
      if (!hold) begin
         @(posedge clk); #1;
         chk("valid_one_cycle", int'(bus.out_valid), 0);
         chk("back_idle", int'(bus.busy), 0);
      end
   endtask

   task automatic set3(input int a0, b0, a1, b1, a2, b2);
      va[0] = D_W'(a0); vb[0] = D_W'(b0);
      va[1] = D_W'(a1); vb[1] = D_W'(b1);
      va[2] = D_W'(a2); vb[2] = D_W'(b2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b1;

      @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      chk("rst_mac_init", int'(bus.mac_init), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 1*2 + 3*4 + 5*6 = 44, back to back
      set3(1, 2, 3, 4, 5, 6);
      do_cmd(3, 0, 44, 1'b0);

      // 2 * 225 = 450 -> 194 mod 256
      set3(15, 15, 15, 15, 0, 0);
      do_cmd(2, 0, 194, 1'b0);

      // 44 again with two-cycle bubbles between beats
      set3(1, 2, 3, 4, 5, 6);
      do_cmd(3, 2, 44, 1'b0);

      // zero-length command: result 0 right after start
      do_cmd(0, 0, 0, 1'b0);

      // result held under back-pressure, start ignored in DONE
      bus.out_ready = 1'b0;
      do_cmd(3, 0, 44, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         bus.start = (k % 2 == 0);
         bus.len   = 8'd3;
         @(negedge clk);
         chk("hold_out_valid", int'(bus.out_valid), 1);
         chk("hold_out_data", int'(bus.out_data), 44);
         chk("hold_in_ready", int'(bus.in_ready), 0);
      end
      @(posedge clk); #1;
      bus.start     = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("post_hs_busy", int'(bus.busy), 0);
      chk("post_hs_in_ready", int'(bus.in_ready), 0);

      set3(15, 15, 15, 15, 0, 0);
      do_cmd(2, 0, 194, 1'b0);

      // reset after one of three beats, with a beat still presented
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.len   = 8'd3;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a     = 4'd1;
      bus.in_b     = 4'd2;
      @(posedge clk); #1;
      bus.in_a = 4'd3;
      bus.in_b = 4'd4;
      rst_n    = 1'b0;
      @(negedge clk);
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_in_ready", int'(bus.in_ready), 0);
      chk("midrst_mac_a", int'(bus.mac_a), 0);
      chk("midrst_mac_b", int'(bus.mac_b), 0);
      chk("midrst_mac_init", int'(bus.mac_init), 0);
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_out_data", int'(bus.out_data), 0);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 7*3 = 21, initialize overwrites the stale accumulator
      va[0] = 4'd7; vb[0] = 4'd3;
      do_cmd(1, 0, 21, 1'b0);

      // maximum length: 255 * (1*1) = 255, counter must not wrap
      for (int i = 0; i < 255; i++) begin
         va[i] = 4'd1;
         vb[i] = 4'd1;
      end
      do_cmd(255, 0, 255, 1'b0);

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
